// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer-side handshake and TX line bundle for the UART TX arbiter
interface uart_tx_arbiter_if #(
    parameter int ID_W = 2
);
    localparam int NREQ = 2**ID_W;

    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   ack;
    logic              tx;
    logic              busy;
    logic [ID_W-1:0]   grant_id;

    // Producers drive bytes and see acks and the line state.
    modport master (output req, data, last, input ack, tx, busy, grant_id);
    // The arbiter consumes bytes and drives the serial line.
    modport slave  (input req, data, last, output ack, tx, busy, grant_id);
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin UART TX arbiter and frame sequencer (optional header frame: UART_TX_ARB_HDR_EN)
module uart_tx_arbiter #(
    parameter int ID_W      = 2,
    parameter int FREQ      = 12000000,
    parameter int BAUD      = 9600,
    parameter int LIM       = FREQ / BAUD,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               nrst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int NREQ    = 2**ID_W;
    localparam int CNT_W   = ($clog2(LIM) > 11) ? $clog2(LIM) : 11;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(LIM - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

`ifdef UART_TX_ARB_HDR_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_HDR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;
`endif

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_grant;
    logic [NREQ-1:0]    r_ack;
    logic               r_tx;
    logic               r_busy;
    logic               r_last;
    logic [9:0]         r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_bit;
    logic [BURST_W-1:0] r_burst;
`ifdef UART_TX_ARB_HDR_EN
    logic               r_hdr;
`endif

    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W-1:0]    w_idx;
    logic [7:0]         w_byte;

    assign w_byte       = bus.data[8*r_grant +: 8];
    assign bus.ack      = r_ack;
    assign bus.tx       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.grant_id = r_grant;

    // Round-robin pick: first requester at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = r_ptr + i[ID_W-1:0];
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Grant, byte fetch and bit serialization; all outputs are registered.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
            r_shift <= '1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_burst <= '0;
`ifdef UART_TX_ARB_HDR_EN
            r_hdr   <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_busy  <= 1'b1;
                        r_burst <= '0;
`ifdef UART_TX_ARB_HDR_EN
                        r_state <= S_HDR;
`else
                        r_state <= S_LOAD;
`endif
                    end
                end
`ifdef UART_TX_ARB_HDR_EN
                S_HDR: begin
                    r_shift <= {1'b0, 8'hA0 | 8'(r_grant), 1'b1};
                    r_tx    <= 1'b0;
                    r_cnt   <= '0;
                    r_bit   <= '0;
                    r_hdr   <= 1'b1;
                    r_state <= S_SHIFT;
                end
`endif
                S_LOAD: begin
                    if (!bus.req[r_grant]) begin
                        r_ptr   <= r_grant + 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ack[r_grant] <= 1'b1;
                        r_last  <= bus.last[r_grant];
                        r_shift <= {1'b0, w_byte, 1'b1};
                        r_tx    <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_burst <= r_burst + 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (r_bit != 4'd9) begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {r_shift[8:0], 1'b1};
                            r_tx    <= r_shift[8];
                        end else begin
`ifdef UART_TX_ARB_HDR_EN
                            if (r_hdr) begin
                                r_hdr   <= 1'b0;
                                r_state <= S_LOAD;
                            end else
`endif
                            if (r_last || (r_burst == BURST_MAX)) begin
                                r_ptr   <= r_grant + 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int ID_W = 2;
    localparam int LIM  = 10;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_arbiter_if #(.ID_W(ID_W)) bus();

    uart_tx_arbiter #(
        .ID_W(ID_W), .FREQ(100), .BAUD(10), .MAX_BURST(4)
    ) dut (
        .clk(clk), .nrst(nrst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic do_reset;
        bus.req  = '0;
        bus.last = '0;
        bus.data = '0;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    // Samples one frame starting at its first clock; returns first and last sample of each bit.
    task automatic capture(output logic [9:0] f0, output logic [9:0] f9,
                           output int nack, output logic busy_end);
        f0 = '0; f9 = '0; nack = 0; busy_end = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < LIM; c++) begin
                if (c == 0)       f0[9-k] = bus.tx;
                if (c == LIM - 1) f9[9-k] = bus.tx;
                if (bus.ack != '0) nack++;
                busy_end = bus.busy;
                @(negedge clk);
            end
        end
    endtask

    // From the negedge where req was raised, advance to the first clock of the first data frame.
    task automatic start_grant;
`ifdef UART_TX_ARB_HDR_EN
        logic [9:0] h0, h9;
        int hn;
        logic hb;
`endif
        @(negedge clk);
`ifdef UART_TX_ARB_HDR_EN
        @(negedge clk);
        capture(h0, h9, hn, hb);
`endif
        @(negedge clk);
    endtask

    task automatic wait_not_busy(output int w);
        w = 0;
        while (bus.busy && w < 400) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", bus.tx); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", bus.ack); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", bus.grant_id); end
    endtask

    task automatic test_single;
        logic [9:0] f0, f9;
        int n;
        logic b;
        do_reset;
        bus.data = 32'h005A_0000;
        bus.last = 4'b0100;
        bus.req  = 4'b0100;
        start_grant;
        checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b exp 0100", bus.ack); end
        checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant got %0d exp 2", bus.grant_id); end
        bus.req = '0;
        capture(f0, f9, n, b);
        checks++; if (f0 !== 10'b0010110101) begin errors++; $display("FAIL single_frame_head got %b exp 0010110101", f0); end
        checks++; if (f9 !== 10'b0010110101) begin errors++; $display("FAIL single_frame_tail got %b exp 0010110101", f9); end
        checks++; if (n !== 1) begin errors++; $display("FAIL single_ack_count got %0d exp 1", n); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL single_busy_stop got %b exp 1", b); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", bus.busy); end
        checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL single_tx_idle got %b exp 1", bus.tx); end
        checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_hold got %0d exp 2", bus.grant_id); end
    endtask

    task automatic test_burst_cap;
        logic [9:0] f0, f9;
        int n, total, w;
        logic b;
        do_reset;
        bus.data = 32'h0000_00C3;
        bus.last = 4'b0000;
        bus.req  = 4'b0001;
        start_grant;
        total = 0;
        for (int f = 0; f < 4; f++) begin
            checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL burst_ack%0d got %b exp 0001", f, bus.ack); end
            capture(f0, f9, n, b);
            total += n;
            checks++; if (f0 !== 10'b0110000111 || f9 !== 10'b0110000111) begin
                errors++; $display("FAIL burst_frame%0d got %b/%b exp 0110000111", f, f0, f9); end
            checks++; if (bus.tx !== 1'b1 || bus.ack !== 4'b0000) begin
                errors++; $display("FAIL burst_gap%0d got tx=%b ack=%b exp tx=1 ack=0000", f, bus.tx, bus.ack); end
            checks++; if (bus.busy !== (f < 3)) begin
                errors++; $display("FAIL burst_busy%0d got %b exp %b", f, bus.busy, (f < 3)); end
            if (f < 3) @(negedge clk);
        end
        checks++; if (total !== 4) begin errors++; $display("FAIL burst_ack_total got %0d exp 4", total); end
        bus.req  = 4'b0011;
        bus.last = 4'b0010;
        @(negedge clk);
        checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL burst_next_grant got %0d exp 1", bus.grant_id); end
        bus.req = '0;
        wait_not_busy(w);
        checks++; if (w >= 400) begin errors++; $display("FAIL burst_drain got %0d exp <400", w); end
    endtask

    task automatic test_fairness;
        int exp_id [6] = '{0, 1, 3, 0, 1, 3};
        logic [3:0] exp_ack;
        int w;
        do_reset;
        bus.data = 32'h1122_3344;
        bus.last = 4'b1111;
        bus.req  = 4'b1011;
        for (int n = 0; n < 6; n++) begin
            w = 0;
            while (bus.ack == 4'b0000 && w < 400) begin
                @(negedge clk);
                w++;
            end
            exp_ack = 4'b0001 << exp_id[n];
            checks++; if (w >= 400) begin errors++; $display("FAIL fair_timeout%0d got %0d exp <400", n, w); end
            checks++; if (bus.ack !== exp_ack || bus.grant_id !== exp_id[n][1:0]) begin
                errors++; $display("FAIL fair_order%0d got ack=%b id=%0d exp ack=%b id=%0d",
                                   n, bus.ack, bus.grant_id, exp_ack, exp_id[n]); end
            @(negedge clk);
        end
        bus.req = '0;
        wait_not_busy(w);
        checks++; if (w >= 400) begin errors++; $display("FAIL fair_drain got %0d exp <400", w); end
    endtask

    task automatic test_early_drop;
        logic [9:0] f0, f9;
        int n;
        logic b;
        do_reset;
        bus.data = 32'h0000_A500;
        bus.last = 4'b0000;
        bus.req  = 4'b0010;
        start_grant;
        checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL drop_ack got %b exp 0010", bus.ack); end
        bus.req = '0;
        capture(f0, f9, n, b);
        checks++; if (f0 !== 10'b0101001011 || f9 !== 10'b0101001011) begin
            errors++; $display("FAIL drop_frame got %b/%b exp 0101001011", f0, f9); end
        checks++; if (n !== 1) begin errors++; $display("FAIL drop_ack_count got %0d exp 1", n); end
        checks++; if (bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
            errors++; $display("FAIL drop_load got busy=%b ack=%b exp busy=1 ack=0000", bus.busy, bus.ack); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000 || bus.tx !== 1'b1) begin
            errors++; $display("FAIL drop_idle got busy=%b ack=%b tx=%b exp 0/0000/1", bus.busy, bus.ack, bus.tx); end
    endtask

    task automatic test_reset_mid;
        int viol;
        do_reset;
        bus.data = 32'h0000_0000;
        bus.last = 4'b1000;
        bus.req  = 4'b1000;
        start_grant;
        checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL rmid_grant got %0d exp 3", bus.grant_id); end
        repeat (45) @(negedge clk);
        checks++; if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL rmid_pre got tx=%b busy=%b exp 0/1", bus.tx, bus.busy); end
        #1 nrst = 1'b0;
        #1;
        checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== 4'b0000 || bus.grant_id !== 2'd0) begin
            errors++; $display("FAIL rmid_async got tx=%b busy=%b ack=%b id=%0d exp 1/0/0000/0",
                               bus.tx, bus.busy, bus.ack, bus.grant_id); end
        bus.req = '0;
        @(negedge clk);
        nrst = 1'b1;
        viol = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rmid_quiet got %0d exp 0", viol); end
    endtask

`ifdef UART_TX_ARB_HDR_EN
    task automatic test_header;
        logic [9:0] f0, f9;
        int n;
        logic b;
        do_reset;
        bus.data = 32'h3C00_0000;
        bus.last = 4'b1000;
        bus.req  = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        capture(f0, f9, n, b);
        checks++; if (f0 !== 10'b0101000111 || f9 !== 10'b0101000111) begin
            errors++; $display("FAIL hdr_frame got %b/%b exp 0101000111", f0, f9); end
        checks++; if (n !== 0) begin errors++; $display("FAIL hdr_ack_count got %0d exp 0", n); end
        @(negedge clk);
        checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL hdr_data_ack got %b exp 1000", bus.ack); end
        bus.req = '0;
        capture(f0, f9, n, b);
        checks++; if (f0 !== 10'b0001111001 || f9 !== 10'b0001111001) begin
            errors++; $display("FAIL hdr_data_frame got %b/%b exp 0001111001", f0, f9); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hdr_busy_end got %b exp 0", bus.busy); end
    endtask
`endif

    initial begin
        bus.req  = '0;
        bus.last = '0;
        bus.data = '0;
        test_reset;
        test_single;
        test_burst_cap;
        test_fairness;
        test_early_drop;
        test_reset_mid;
`ifdef UART_TX_ARB_HDR_EN
        test_header;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and frame sequencer that shares one UART transmit line among NREQ byte producers. It grants one requester at a time and pulls a burst of up to MAX_BURST bytes from it. Each byte is serialized as a 10-bit frame at the configured baud rate. It sits between the receive/buffer blocks and the board TX pin, and replaces ad-hoc per-block TX logic.

## Interface
- ID_W, 2: requester index width; NREQ = 2**ID_W requesters.
- FREQ, 12000000: clk frequency in Hz.
- BAUD, 9600: line rate in bits/s.
- LIM, FREQ/BAUD: clocks per bit period (1250 at default); counter width 11 bits minimum.
- MAX_BURST, 4: maximum data bytes per grant.

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester "byte available" level.
- data  input  8*NREQ  byte of requester i on data[8i+7:8i]; stable while req[i] is high.
- last  input  NREQ  qualifies the current byte as the final byte of requester i's burst.
- ack  output  NREQ  one-clk pulse: the byte of requester i has been taken; the requester advances its data after this pulse.
- tx  output  1  serial line, idle high.
- busy  output  1  high from grant until the burst's final stop bit completes.
- grant_id  output  ID_W  currently or last granted requester.

## Operation
- States: IDLE, LOAD, SHIFT (plus HDR when UART_TX_ARB_HDR_EN is defined).
- IDLE:
  - Round-robin search of req starting at pointer ptr (reset 0), ascending with wrap.
  - On the first set bit: grant_id <= index, busy <= 1, burst count <= 0, go to LOAD (or HDR).
  - No req set: stay in IDLE.
- LOAD:
  - If req[grant_id] = 0: end the burst with no ack.
  - Otherwise:
    - Pulse ack[grant_id].
    - Latch data and last.
    - Load the 10-bit shift frame {start 0, d7..d0, stop 1}.
    - Increment burst count.
    - Go to SHIFT.
- SHIFT:
  - Frame is transmitted MSB-first, matching the existing TX path: start bit, d7 down to d0, then stop bit.
  - Each bit is held exactly LIM clocks, using a baud counter 0..LIM-1.
  - After the stop bit's LIM clocks:
    - If latched last = 1 or burst count = MAX_BURST: end the burst.
    - Otherwise: go to LOAD.
- End of burst: ptr <= grant_id+1 (mod NREQ), busy <= 0, go to IDLE. grant_id holds its value.
- Only one requester is served per grant. Other requesters' req are ignored until IDLE.
- Reset, including mid-frame, immediately forces:
  - tx=1, busy=0, ack=0, grant_id=0, ptr=0, state IDLE.
  - All counters 0.
  - The partial frame is abandoned.

## Timing
- E0: IDLE sees req. E1: LOAD asserts ack for one cycle, and tx falls (start bit) at E1.
- Frame length is 10*LIM clocks. Between consecutive frames of a burst there is exactly 1 extra clk of tx=1, spent in LOAD.
- busy falls on the edge after the final stop bit's LIM-th clock. A new grant is possible one edge later.
- ack never asserts for more than one bit at a time, and never during SHIFT.
- Simultaneous req[i] and req[j]: the index nearest at or above ptr wins. A requester re-asserting immediately after its own burst waits behind any other pending requester.
- A change of data or last while ack is low has no effect once LOAD has latched.

## Configuration
- UART_TX_ARB_HDR_EN defined:
  - HDR state runs once per grant, before the first LOAD.
  - It sends a header frame with byte 8'hA0 | grant_id, with no ack.
  - The header does not count toward MAX_BURST.
  - If req drops before the first LOAD, the header has already been sent and the burst ends with zero data bytes.
- UART_TX_ARB_HDR_EN undefined: no HDR state. Data frames start directly at LOAD. Timing is as above.

## Test plan
Use FREQ=100 and BAUD=10, giving LIM=10.
- Single byte: req[2]=1, data byte 2=8'h5A, last[2]=1.
  - Response: ack[2] pulses once.
  - tx = 0,0,1,0,1,1,0,1,0,1, each bit 10 clk.
  - busy drops 100 clk after the start bit; grant_id=2.
- Burst cap: req[0] held high, last=0.
  - Response: exactly 4 ack[0] pulses and 4 frames, each separated by 1 idle clk.
  - Then busy=0 and ptr=1.
- Fairness: req=4'b1011 continuously, single-byte bursts.
  - Response: grant order is 0,1,3,0,1,3.
- Early drop: req[1] falls while frame 1 is in SHIFT, with last=0.
  - Response: frame 1 completes; no second ack; IDLE one clk after the stop bit.
- Reset mid-frame: nrst low during bit 4.
  - Response: tx=1, busy=0, ack=0, grant_id=0 asynchronously.
  - After release with no req, tx stays 1.
- Header (with UART_TX_ARB_HDR_EN): req[3], 1 byte.
  - Response: frame 8'hA3 sent first without ack, then the data frame with ack[3].
